// File: rtl/mem_arbiter_if.sv
// Bundle between the three requesters, the arbiter and mem_space.
// slave = arbiter side, master = requester/memory side.
interface mem_arbiter_if #(
  parameter int SIZE = 16
);
  logic [2:0]        req;
  logic [2:0]        lock;
  logic [2:0]        req_we;
  logic [2:0]        req_bw;
  logic [3*SIZE-1:0] req_addr;
  logic [3*SIZE-1:0] req_wdata;
  logic [2:0]        gnt;
  logic [2:0]        done;
  logic [SIZE-1:0]   rdata;
  logic [SIZE-1:0]   MAB_in;
  logic [SIZE-1:0]   MDB_in;
  logic              MW;
  logic              BW;
  logic [SIZE-1:0]   MDB_out;

  modport slave (
    input  req, lock, req_we, req_bw, req_addr, req_wdata, MDB_out,
    output gnt, done, rdata, MAB_in, MDB_in, MW, BW
  );

  modport master (
    output req, lock, req_we, req_bw, req_addr, req_wdata, MDB_out,
    input  gnt, done, rdata, MAB_in, MDB_in, MW, BW
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares mem_space among fetch(0), operand(1), stack(2); priority 1>2>0 with fetch starvation guard.
// Latency: decision -> MEM_LAT ACCESS cycles -> done; requesters hold req until done (no other backpressure).
module mem_arbiter #(
  parameter int SIZE       = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [LW-1:0] LAT_LAST   = LW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  logic [1:0]      state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [SIZE-1:0] addr_q, addr_d;
  logic [SIZE-1:0] wdata_q, wdata_d;
  logic            we_q, we_d;
  logic            bw_q, bw_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [SIZE-1:0] rdata_q, rdata_d;

  logic [1:0]      win;
  logic [1:0]      sel;
  logic            decide;
  logic            lock_go;
  logic [SIZE-1:0] cmd_addr, cmd_wdata;
  logic [SIZE-1:0] rd_fmt;
  logic            in_access, in_resp;

  always_comb begin
    if (bus.req[0] && starve_q == STARVE_TOP) win = 2'd0;
    else if (bus.req[1])                       win = 2'd1;
    else if (bus.req[2])                       win = 2'd2;
    else                                       win = 2'd0;
  end

  assign lock_go = bus.lock[owner_q] && bus.req[owner_q] && (starve_q < STARVE_TOP);

  always_comb begin
    case (sel)
      2'd1: begin
        cmd_addr  = bus.req_addr[SIZE +: SIZE];
        cmd_wdata = bus.req_wdata[SIZE +: SIZE];
      end
      2'd2: begin
        cmd_addr  = bus.req_addr[2*SIZE +: SIZE];
        cmd_wdata = bus.req_wdata[2*SIZE +: SIZE];
      end
      default: begin
        cmd_addr  = bus.req_addr[0 +: SIZE];
        cmd_wdata = bus.req_wdata[0 +: SIZE];
      end
    endcase
  end

  assign rd_fmt = bw_q ? {{(SIZE-8){1'b0}}, bus.MDB_out[7:0]} : bus.MDB_out;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    bw_d     = bw_q;
    lat_d    = lat_q;
    starve_d = starve_q;
    rdata_d  = rdata_q;
    decide   = 1'b0;
    sel      = win;
    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          decide  = 1'b1;
          state_d = S_ACCESS;
          lat_d   = '0;
        end
      end
      S_ACCESS: begin
        if (lat_q == LAT_LAST) state_d = S_RESP;
        else                   lat_d   = lat_q + LW'(1);
      end
      S_RESP: begin
        if (!we_q) rdata_d = rd_fmt;
        // Locked follow-on skips IDLE but still counts toward fetch starvation.
        if (lock_go) begin
          decide  = 1'b1;
          sel     = owner_q;
          state_d = S_ACCESS;
          lat_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (decide) begin
      owner_d = sel;
      addr_d  = cmd_addr;
      wdata_d = cmd_wdata;
      we_d    = bus.req_we[sel];
      bw_d    = bus.req_bw[sel];
      if (bus.req[0] && sel != 2'd0)
        starve_d = (starve_q == STARVE_TOP) ? starve_q : starve_q + SW'(1);
      else
        starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      bw_q     <= 1'b0;
      lat_q    <= '0;
      starve_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      bw_q     <= bw_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      rdata_q  <= rdata_d;
    end
  end

  assign in_access = (state_q == S_ACCESS);
  assign in_resp   = (state_q == S_RESP);

  // Outputs decode straight from state so an async reset silences them at once.
  assign bus.gnt    = in_access ? (3'b001 << owner_q) : 3'b000;
  assign bus.done   = in_resp   ? (3'b001 << owner_q) : 3'b000;
  assign bus.rdata  = (in_resp && !we_q) ? rd_fmt : rdata_q;
  assign bus.MAB_in = in_access ? addr_q  : '0;
  assign bus.MDB_in = in_access ? wdata_q : '0;
  assign bus.MW     = in_access && we_q && (lat_q == '0);
  assign bus.BW     = in_access && bw_q;
endmodule
